// File: rtl/sad_pkg.sv
// Shared types and defaults for the sum-of-absolute-differences engine.
package sad_pkg;

  localparam int unsigned N_DEF      = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OUT_W_DEF  = 32;

  // Control states: waiting for start, accumulating N pairs, publishing result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // |a-b| for default-width samples, computed one bit wider so no wrap occurs.
  function automatic logic [DATA_W_DEF-1:0] absdiff(
    input logic [DATA_W_DEF-1:0] a,
    input logic [DATA_W_DEF-1:0] b
  );
    logic [DATA_W_DEF:0] diff;
    logic [DATA_W_DEF:0] mag;
    diff = {1'b0, a} - {1'b0, b};
    mag  = diff[DATA_W_DEF] ? ((~diff) + (DATA_W_DEF+1)'(1)) : diff;
    return mag[DATA_W_DEF-1:0];
  endfunction

endpackage : sad_pkg

// File: rtl/sad_absdiff.sv
// Combinational unsigned absolute difference of two DATA_W-bit samples.
// Ports:
//   a, b : unsigned samples
//   d_c  : |a-b|, same width as the samples
module sad_absdiff
  import sad_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] d_c
);

  logic [DATA_W:0] diff;
  logic [DATA_W:0] mag;

  // Subtract at DATA_W+1 bits; the top bit is the borrow, i.e. b > a.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    mag  = diff[DATA_W] ? ((~diff) + (DATA_W+1)'(1)) : diff;
    d_c  = mag[DATA_W-1:0];
  end

endmodule : sad_absdiff

// File: rtl/sad.sv
// Sum-of-absolute-differences engine. A one-cycle enb pulse in IDLE starts an
// operation that accumulates |dta_in-dtb_in| over N consecutive cycles, then
// publishes the total on dt_o, where it is held until the next completion.
// Ports:
//   clk    : rising-edge clock
//   enb    : start strobe, only looked at in IDLE
//   rst    : synchronous active-high reset
//   dta_in : sample A (unsigned)
//   dtb_in : sample B (unsigned)
//   dt_o   : result of the last completed operation (registered)
//   busy_o : high while an operation is in progress (state decode)
module sad
  import sad_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              enb,
  input  logic              rst,
  input  logic [DATA_W-1:0] dta_in,
  input  logic [DATA_W-1:0] dtb_in,
  output logic [OUT_W-1:0]  dt_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   dt_d;
  logic [DATA_W-1:0]  ad_c;

  sad_absdiff #(
    .DATA_W (DATA_W)
  ) u_absdiff (
    .a   (dta_in),
    .b   (dtb_in),
    .d_c (ad_c)
  );

  // State, counter, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dt_o    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dt_o    <= dt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dt_d    = dt_o;
    unique case (state_q)
      IDLE: begin
        if (enb) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + OUT_W'(ad_c);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dt_d    = acc_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule : sad

// File: tb/tb_sad.sv
// Directed and randomized bench for the sad engine with a behavioural model.
module tb_sad;

  localparam int unsigned N = 16;

  logic        clk;
  logic        enb;
  logic        rst;
  logic [7:0]  dta_in;
  logic [7:0]  dtb_in;
  logic [31:0] dt_o;
  logic        busy_o;

  int checks;
  int errors;
  int va [N];
  int vb [N];
  logic [31:0] last_dt;

  sad dut (
    .clk    (clk),
    .enb    (enb),
    .rst    (rst),
    .dta_in (dta_in),
    .dtb_in (dtb_in),
    .dt_o   (dt_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of |a-b| over the loaded vectors.
  function automatic int model_sum();
    int s;
    s = 0;
    for (int i = 0; i < int'(N); i++) begin
      s += (va[i] > vb[i]) ? (va[i] - vb[i]) : (vb[i] - va[i]);
    end
    return s;
  endfunction

  // One full operation; inputs are presented in the N cycles after the start edge.
  task automatic run_op(input string tag, input bit hold_en);
    int exp_sum;
    int busy_cnt;
    exp_sum  = model_sum();
    busy_cnt = 0;
    enb = 1'b1;
    @(posedge clk); #1;
    if (!hold_en) enb = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      dta_in = 8'(va[i]);
      dtb_in = 8'(vb[i]);
      if (busy_o === 1'b1) busy_cnt++;
      check({tag, "_dt_hold"}, dt_o, last_dt);
      @(posedge clk); #1;
    end
    dta_in = 8'($urandom_range(255, 0));
    dtb_in = 8'($urandom_range(255, 0));
    if (busy_o === 1'b1) busy_cnt++;
    @(posedge clk); #1;
    enb = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N + 1));
    check({tag, "_busy_low"}, 32'(busy_o), 32'd0);
    check({tag, "_result"}, dt_o, 32'(exp_sum));
    last_dt = 32'(exp_sum);
  endtask

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < int'(N); i++) begin
      va[i] = a;
      vb[i] = b;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(N); i++) begin
      va[i] = int'($urandom_range(255, 0));
      vb[i] = int'($urandom_range(255, 0));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    last_dt = 32'd0;
    enb     = 1'b0;
    rst     = 1'b1;
    dta_in  = 8'd0;
    dtb_in  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_dt", dt_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy_o), 32'd0);

    fill_const(24, 32);
    run_op("a24_b32", 1'b0);
    fill_const(32, 24);
    run_op("a32_b24", 1'b0);
    fill_const(77, 77);
    run_op("equal", 1'b0);
    fill_const(255, 0);
    run_op("max", 1'b0);
    for (int k = 0; k < int'(N); k++) begin
      va[k] = k;
      vb[k] = 2 * k;
    end
    run_op("ramp", 1'b0);

    fill_rand();
    run_op("enb_held", 1'b1);
    fill_rand();
    run_op("back_to_back", 1'b0);

    // Abort after 8 accumulations; partial sum must vanish and dt_o clear.
    fill_rand();
    enb = 1'b1;
    @(posedge clk); #1;
    enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dta_in = 8'(va[i]);
      dtb_in = 8'(vb[i]);
      @(posedge clk); #1;
    end
    check("pre_abort_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_dt", dt_o, 32'd0);
    last_dt = 32'd0;
    @(posedge clk); #1;
    check("abort_idle_dt", dt_o, 32'd0);

    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_op($sformatf("rand%0d", r), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sad
